// File: rtl/rib_rr_arbiter_if.sv
// RIB arbiter handshake bundle: master request/lock lines in, registered grant and core hold flag out.
interface rib_rr_arbiter_if;
  logic [3:0] req_i;
  logic [3:0] lock_i;
  logic       rr_en_i;
  logic [3:0] grant_o;
  logic [1:0] grant_id_o;
  logic       grant_vld_o;
  logic       hold_flag_o;

  modport master (
    output req_i, lock_i, rr_en_i,
    input  grant_o, grant_id_o, grant_vld_o, hold_flag_o
  );

  modport slave (
    input  req_i, lock_i, rr_en_i,
    output grant_o, grant_id_o, grant_vld_o, hold_flag_o
  );
endinterface

// File: rtl/rib_rr_arbiter.sv
// Registered 4-master RIB arbiter: round-robin or fixed priority, locked bursts bounded by MAX_HOLD.
module rib_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input logic             clk,
  input logic             rst,
  rib_rr_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_p1, state_nxt;
  logic [3:0]       grant_p1, grant_nxt;
  logic [1:0]       grant_id_p1, grant_id_nxt;
  logic             vld_p1, vld_nxt;
  logic [1:0]       ptr_p1, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt_p1, hold_cnt_nxt;

  logic [3:0] others;
  logic       owner_locked;
  logic       cont;
  logic [3:0] cand;
  logic [1:0] win;

  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    pick_rr = 2'd0;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        pick_rr = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    pick_fixed = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) pick_fixed = 2'(i);
    end
  endfunction

  // A locked owner only stays a candidate when nobody else is asking.
  assign others       = bus.req_i & ~grant_p1;
  assign owner_locked = (state_p1 == ST_GRANT) && |(bus.req_i & bus.lock_i & grant_p1);
  assign cont         = owner_locked && (hold_cnt_p1 < HOLD_LAST);
  assign cand         = (owner_locked && (others != 4'd0)) ? others : bus.req_i;
  assign win          = bus.rr_en_i ? pick_rr(cand, ptr_p1) : pick_fixed(cand);

  always_comb begin
    state_nxt    = state_p1;
    grant_nxt    = grant_p1;
    grant_id_nxt = grant_id_p1;
    vld_nxt      = vld_p1;
    ptr_nxt      = ptr_p1;
    hold_cnt_nxt = hold_cnt_p1;
    if (cont) begin
      hold_cnt_nxt = hold_cnt_p1 + CNT_W'(1);
    end else if (cand != 4'd0) begin
      state_nxt    = ST_GRANT;
      grant_nxt    = 4'b0001 << win;
      grant_id_nxt = win;
      vld_nxt      = 1'b1;
      ptr_nxt      = win + 2'd1;
      hold_cnt_nxt = '0;
    end else begin
      state_nxt    = ST_IDLE;
      grant_nxt    = 4'd0;
      grant_id_nxt = 2'd0;
      vld_nxt      = 1'b0;
      hold_cnt_nxt = '0;
    end
  end

  // p1: registered grant state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1    <= ST_IDLE;
      grant_p1    <= 4'd0;
      grant_id_p1 <= 2'd0;
      vld_p1      <= 1'b0;
      ptr_p1      <= 2'd0;
      hold_cnt_p1 <= '0;
    end else begin
      state_p1    <= state_nxt;
      grant_p1    <= grant_nxt;
      grant_id_p1 <= grant_id_nxt;
      vld_p1      <= vld_nxt;
      ptr_p1      <= ptr_nxt;
      hold_cnt_p1 <= hold_cnt_nxt;
    end
  end

  assign bus.grant_o     = grant_p1;
  assign bus.grant_id_o  = grant_id_p1;
  assign bus.grant_vld_o = vld_p1;
  assign bus.hold_flag_o = rst & ((bus.req_i[0] & ~grant_p1[0]) | (bus.req_i[1] & ~grant_p1[1]));

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Directed bench for rib_rr_arbiter: reset, round-robin, fixed priority, lock tenure, early release, async reset.
module tb_rib_rr_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rib_rr_arbiter_if bus ();

  rib_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] exp_id, input logic exp_vld);
    logic [3:0] exp_g;
    exp_g = exp_vld ? (4'b0001 << exp_id) : 4'b0000;
    chk({tag, ".grant"}, 8'(bus.grant_o), 8'(exp_g));
    chk({tag, ".id"}, 8'(bus.grant_id_o), 8'(exp_vld ? exp_id : 2'd0));
    chk({tag, ".vld"}, 8'(bus.grant_vld_o), 8'(exp_vld));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_seq [7];
    checks = 0;
    errors = 0;
    rr_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    // Reset held with all masters requesting
    rst         = 1'b0;
    bus.req_i   = 4'hF;
    bus.lock_i  = 4'h0;
    bus.rr_en_i = 1'b1;
    tick();
    tick();
    chk_grant("rst_hold", 2'd0, 1'b0);
    chk("rst_hold.hflag", 8'(bus.hold_flag_o), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_grant("rst_release", 2'd0, 1'b1);

    // Round-robin fairness with all unlocked requests
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_grant($sformatf("rr_%0d", i), rr_seq[i], 1'b1);
    end
    chk("rr.hflag", 8'(bus.hold_flag_o), 8'd1);

    // Fixed priority
    bus.rr_en_i = 1'b0;
    bus.req_i   = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_grant($sformatf("fix_%0d", i), 2'd2, 1'b1);
    end
    chk("fix.hflag_m0m1", 8'(bus.hold_flag_o), 8'd1);
    bus.req_i = 4'b0011;
    tick();
    chk_grant("fix_drop2", 2'd1, 1'b1);
    chk("fix_drop2.hflag", 8'(bus.hold_flag_o), 8'd1);
    bus.req_i = 4'b0010;
    tick();
    chk_grant("fix_sole1", 2'd1, 1'b1);
    chk("fix_sole1.hflag", 8'(bus.hold_flag_o), 8'd0);

    // Locked burst by m2 while m0 waits: 8 cycles, then forced release to m0
    bus.rr_en_i = 1'b1;
    bus.req_i   = 4'b0101;
    bus.lock_i  = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_grant($sformatf("lock_%0d", i), 2'd2, 1'b1);
    end
    chk("lock.hflag", 8'(bus.hold_flag_o), 8'd1);
    tick();
    chk_grant("lock_release", 2'd0, 1'b1);

    // m2 sole locked requester: tenure wraps, then m0 joins and gets in after a full fresh tenure
    bus.req_i = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_grant($sformatf("sole_%0d", i), 2'd2, 1'b1);
      if (i == 8) bus.req_i = 4'b0101;
    end
    tick();
    chk_grant("sole_release", 2'd0, 1'b1);

    // Early release of an m3 burst hands straight to m1, then idle
    bus.req_i  = 4'b1000;
    bus.lock_i = 4'b1000;
    tick();
    chk_grant("early_m3_0", 2'd3, 1'b1);
    bus.req_i = 4'b1010;
    tick();
    chk_grant("early_m3_1", 2'd3, 1'b1);
    chk("early.hflag", 8'(bus.hold_flag_o), 8'd1);
    tick();
    chk_grant("early_m3_2", 2'd3, 1'b1);
    bus.req_i  = 4'b0010;
    bus.lock_i = 4'b0000;
    tick();
    chk_grant("early_m1", 2'd1, 1'b1);
    bus.req_i = 4'b0000;
    tick();
    chk_grant("early_idle", 2'd0, 1'b0);
    tick();
    chk_grant("early_idle2", 2'd0, 1'b0);

    // lock without req has no effect
    bus.lock_i = 4'b1111;
    tick();
    chk_grant("lock_noreq", 2'd0, 1'b0);

    // Async reset during an m2 burst
    bus.req_i  = 4'b0100;
    bus.lock_i = 4'b0100;
    tick();
    chk_grant("arst_m2_0", 2'd2, 1'b1);
    tick();
    chk_grant("arst_m2_1", 2'd2, 1'b1);
    #2;
    rst       = 1'b0;
    bus.req_i = 4'b0111;
    #1;
    chk_grant("arst_mid", 2'd0, 1'b0);
    chk("arst_mid.hflag", 8'(bus.hold_flag_o), 8'd0);
    tick();
    chk_grant("arst_held", 2'd0, 1'b0);
    @(negedge clk);
    rst        = 1'b1;
    bus.req_i  = 4'hF;
    bus.lock_i = 4'h0;
    tick();
    chk_grant("arst_restart", 2'd0, 1'b1);
    tick();
    chk_grant("arst_restart_rr", 2'd1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
